// File: rtl/vga_tile_fetch_arbiter.sv
// Tile/glyph fetch arbiter for the 40x30 text-mode VGA path.
// Owns the single-port tile RAM and the glyph ROM: video prefetches of the
// next tile's glyph row always win, CPU accesses take the remaining IDLE cycles.
//
// state | meaning
// IDLE  | port free; start a video fetch on vtrig, else grant a pending CPU access
// VT    | tile RAM data valid; issue glyph ROM address
// VG    | glyph ROM data valid; capture the prefetched row
module vga_tile_fetch_arbiter #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int FETCH_SLOT = 8,
    parameter int GW         = 5
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        de,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        line_start,
    output logic [10:0] tile_addr,
    output logic        tile_we,
    output logic [7:0]  tile_wdata,
    input  logic [7:0]  tile_rdata,
    output logic [8:0]  glyph_addr,
    input  logic [15:0] glyph_rdata,
    output logic [15:0] pix_row,
    output logic        pix_on,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VT   = 2'd1,
        VG   = 2'd2
    } state_t;

    localparam logic [6:0]  COLS_W  = 7'(COLS);
    localparam logic [3:0]  SLOT_W  = 4'(FETCH_SLOT);
    localparam logic [10:0] TILES_W = 11'(COLS * ROWS);

    state_t       state_q, state_d;
    logic [10:0]  tile_addr_q, tile_addr_d;
    logic         tile_we_q, tile_we_d;
    logic [7:0]   tile_wdata_q, tile_wdata_d;
    logic [8:0]   glyph_addr_q, glyph_addr_d;
    logic [15:0]  next_row_q, next_row_d;
    logic [15:0]  pix_row_q, pix_row_d;
    logic         cpu_gnt_q, cpu_gnt_d;
    logic [7:0]   cpu_rdata_q, cpu_rdata_d;
    logic         cpu_rvalid_q, cpu_rvalid_d;
    logic         cpu_err_q, cpu_err_d;
    logic         rd_pend_q, rd_pend_d;
    logic         rd_err_q, rd_err_d;
    logic         ls_pend_q, ls_pend_d;

    logic [6:0]   col_next;
    logic [5:0]   tgt_col;
    logic [5:0]   tile_row;
    logic [10:0]  fetch_addr;
    logic         vtrig;
    logic         cpu_oor;
    logic         grant;

    // Video trigger, target tile address (row*40 as two shifts) and CPU grant qualification
    always_comb begin
        col_next   = {1'b0, x[9:4]} + 7'd1;
        vtrig      = line_start | (de & (x[3:0] == SLOT_W) & (col_next < COLS_W));
        tgt_col    = line_start ? 6'd0 : col_next[5:0];
        tile_row   = y[9:4];
        fetch_addr = {tile_row, 5'b0} + {2'b0, tile_row, 3'b0} + {5'b0, tgt_col};
        cpu_oor    = (cpu_addr >= TILES_W);
        // cpu_gnt_q blocks a second grant while the CPU is still dropping its request
        grant      = (state_q == IDLE) & cpu_req & ~vtrig & ~cpu_gnt_q;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        tile_addr_d  = tile_addr_q;
        tile_we_d    = 1'b0;
        tile_wdata_d = tile_wdata_q;
        glyph_addr_d = glyph_addr_q;
        next_row_d   = next_row_q;
        pix_row_d    = pix_row_q;
        cpu_gnt_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        cpu_err_d    = 1'b0;
        rd_pend_d    = 1'b0;
        rd_err_d     = 1'b0;
        ls_pend_d    = ls_pend_q;

        if (de && (x[3:0] == 4'hF)) begin
            pix_row_d = next_row_q;
        end

        case (state_q)
            IDLE: begin
                if (vtrig) begin
                    tile_addr_d = fetch_addr;
                    ls_pend_d   = line_start;
                    state_d     = VT;
                end else if (grant) begin
                    tile_addr_d = cpu_addr;
                    cpu_gnt_d   = 1'b1;
                    cpu_err_d   = cpu_oor;
                    tile_we_d   = cpu_we & ~cpu_oor;
                    if (cpu_we && !cpu_oor) begin
                        tile_wdata_d = cpu_wdata;
                    end
                    rd_pend_d   = ~cpu_we;
                    rd_err_d    = cpu_oor;
                end
            end
            VT: begin
                glyph_addr_d = {tile_rdata[GW-1:0], y[3:0]};
                state_d      = VG;
            end
            VG: begin
                next_row_d = glyph_rdata;
                // Column 0 of a new line goes straight to the display row
                if (ls_pend_q) begin
                    pix_row_d = glyph_rdata;
                    ls_pend_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A granted read completes one cycle later, possibly alongside a VT cycle
        if (rd_pend_q) begin
            cpu_rdata_d  = rd_err_q ? 8'h00 : tile_rdata;
            cpu_rvalid_d = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            tile_addr_q  <= '0;
            tile_we_q    <= 1'b0;
            tile_wdata_q <= '0;
            glyph_addr_q <= '0;
            next_row_q   <= '0;
            pix_row_q    <= '0;
            cpu_gnt_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_err_q     <= 1'b0;
            ls_pend_q    <= 1'b0;
        end else begin
            tile_addr_q  <= tile_addr_d;
            tile_we_q    <= tile_we_d;
            tile_wdata_q <= tile_wdata_d;
            glyph_addr_q <= glyph_addr_d;
            next_row_q   <= next_row_d;
            pix_row_q    <= pix_row_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            rd_pend_q    <= rd_pend_d;
            rd_err_q     <= rd_err_d;
            ls_pend_q    <= ls_pend_d;
        end
    end

    assign tile_addr  = tile_addr_q;
    assign tile_we    = tile_we_q;
    assign tile_wdata = tile_wdata_q;
    assign glyph_addr = glyph_addr_q;
    assign pix_row    = pix_row_q;
    assign pix_on     = de & pix_row_q[~x[3:0]];
    assign cpu_gnt    = cpu_gnt_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_err    = cpu_err_q;

endmodule
